// File: rtl/mic_array_pkg.sv
// mic_array_pkg: shared constants and helpers for the mic-array front end.
//   PCM_W      default PCM sample width (two's complement)
//   NUM_MICS   default number of microphone channels
//   MAX_DELAY  default delay-line depth in samples (power of 2)
//   get_ch / put_ch  read / replace one channel slot of the flat PCM bus
package mic_array_pkg;

    localparam int PCM_W     = 19;
    localparam int NUM_MICS  = 8;
    localparam int MAX_DELAY = 32;

    typedef logic [PCM_W-1:0]          pcm_t;
    typedef logic [NUM_MICS*PCM_W-1:0] pcm_bus_t;

    // Extract channel c from a flat bus (channel c at bits [c*PCM_W +: PCM_W]).
    function automatic pcm_t get_ch(input pcm_bus_t bus, input int unsigned c);
        return bus[c*PCM_W +: PCM_W];
    endfunction

    // Return a copy of the flat bus with channel c replaced by val.
    function automatic pcm_bus_t put_ch(input pcm_bus_t bus, input int unsigned c, input pcm_t val);
        pcm_bus_t r;
        r = bus;
        r[c*PCM_W +: PCM_W] = val;
        return r;
    endfunction

endpackage

// File: rtl/steerable_delay_array_if.sv
// steerable_delay_array_if: sample, configuration and output signals of the
// steerable delay array.
//   master: drives sample_valid/pcm_in, cfg_*, preset_sel/preset_load;
//           receives load_pending, out_valid, pcm_out.
//   slave:  the delay array itself (directions reversed).
interface steerable_delay_array_if #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 19,
    parameter int MAX_DELAY   = 32,
    parameter int NUM_PRESETS = 16
);

    localparam int DEL_W = $clog2(MAX_DELAY);
    localparam int PS_W  = $clog2(NUM_PRESETS);
    localparam int CH_W  = $clog2(NUM_CH);

    logic                     sample_valid;
    logic [NUM_CH*DATA_W-1:0] pcm_in;
    logic                     cfg_wr;
    logic [PS_W-1:0]          cfg_preset;
    logic [CH_W-1:0]          cfg_ch;
    logic [DEL_W-1:0]         cfg_delay;
    logic [PS_W-1:0]          preset_sel;
    logic                     preset_load;
    logic                     load_pending;
    logic                     out_valid;
    logic [NUM_CH*DATA_W-1:0] pcm_out;

    modport master (
        output sample_valid, pcm_in, cfg_wr, cfg_preset, cfg_ch, cfg_delay,
               preset_sel, preset_load,
        input  load_pending, out_valid, pcm_out
    );

    modport slave (
        input  sample_valid, pcm_in, cfg_wr, cfg_preset, cfg_ch, cfg_delay,
               preset_sel, preset_load,
        output load_pending, out_valid, pcm_out
    );

endinterface

// File: rtl/steerable_delay_array_sample_delay_ram.sv
// sample_delay_ram: one channel's delay line storage.
//   clk    clock
//   we     write enable, stores wdata at waddr on the clock edge
//   waddr  write address
//   wdata  sample to store
//   raddr  read address
//   rdata  registered read data (mem[raddr] sampled every edge)
module sample_delay_ram #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 19,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write and registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/steerable_delay_array.sv
// steerable_delay_array: per-channel whole-sample delay with a runtime table
// of steering presets; a preset switch hits all channels on the same sample.
//   clk, rst  clock and asynchronous active-high reset
//   bus       steerable_delay_array_if.slave:
//             sample_valid/pcm_in  input sample set strobe and data
//             cfg_*                table entry write
//             preset_sel/_load     request to apply a preset at next sample
//             load_pending         request waiting for a sample boundary
//             out_valid/pcm_out    delayed sample set, 1 cycle after strobe
module steerable_delay_array #(
    parameter int NUM_CH      = mic_array_pkg::NUM_MICS,
    parameter int DATA_W      = mic_array_pkg::PCM_W,
    parameter int MAX_DELAY   = mic_array_pkg::MAX_DELAY,
    parameter int NUM_PRESETS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    steerable_delay_array_if.slave bus
);

    import mic_array_pkg::*;

    localparam int DEL_W = $clog2(MAX_DELAY);
    localparam int PS_W  = $clog2(NUM_PRESETS);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam logic [DEL_W-1:0] FILL_MAX = DEL_W'(MAX_DELAY - 1);

    logic [DEL_W-1:0]         wp_r;
    logic [DEL_W-1:0]         fill_r;
    logic [DEL_W-1:0]         tbl_r [NUM_PRESETS][NUM_CH];
    logic [DEL_W-1:0]         act_r [NUM_CH];
    logic [PS_W-1:0]          pend_idx_r;
    logic                     load_pending_r;
    logic                     out_valid_r;
    logic [NUM_CH*DATA_W-1:0] pcm_out_r;

    logic [PS_W-1:0]          pend_idx_nxt_s;
    logic                     load_pending_nxt_s;
    logic [DEL_W-1:0]         d_eff_s   [NUM_CH];
    logic [DEL_W-1:0]         d_ahead_s [NUM_CH];
    logic [DEL_W-1:0]         raddr_s   [NUM_CH];
    logic [DATA_W-1:0]        rdata_s   [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] pcm_out_nxt_s;

    // Load request: the latest preset_load wins; a sample edge consumes the
    // request unless a new one arrives in that same cycle.
    always_comb begin
        pend_idx_nxt_s     = pend_idx_r;
        load_pending_nxt_s = load_pending_r;
        if (bus.preset_load) begin
            pend_idx_nxt_s     = bus.preset_sel;
            load_pending_nxt_s = 1'b1;
        end else if (bus.sample_valid) begin
            load_pending_nxt_s = 1'b0;
        end else begin
            load_pending_nxt_s = load_pending_r;
        end
    end

    // Delay selection. d_eff is the delay used for the sample arriving now
    // (a pending preset is applied before the read). The RAM read is
    // registered, so the address is issued one cycle early from d_ahead:
    // the delay that will be in force if the next cycle carries a strobe,
    // forwarding this cycle's load request and table write. Strobes are at
    // least two cycles apart, so wp is already stable when reading ahead.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            d_eff_s[c] = load_pending_r ? tbl_r[pend_idx_r][c] : act_r[c];
            if (load_pending_nxt_s) begin
                if (bus.cfg_wr && (bus.cfg_preset == pend_idx_nxt_s) && (bus.cfg_ch == CH_W'(c))) begin
                    d_ahead_s[c] = bus.cfg_delay;
                end else begin
                    d_ahead_s[c] = tbl_r[pend_idx_nxt_s][c];
                end
            end else begin
                d_ahead_s[c] = act_r[c];
            end
            raddr_s[c] = wp_r - d_ahead_s[c];
        end
    end

    // Output select: zero until the line holds d samples, bypass for d = 0
    // (the current sample is being written this edge), else RAM data.
    always_comb begin
        pcm_out_nxt_s = pcm_out_r;
        for (int c = 0; c < NUM_CH; c++) begin
            if (d_eff_s[c] > fill_r) begin
                pcm_out_nxt_s[c*DATA_W +: DATA_W] = '0;
            end else if (d_eff_s[c] == '0) begin
                pcm_out_nxt_s[c*DATA_W +: DATA_W] = bus.pcm_in[c*DATA_W +: DATA_W];
            end else begin
                pcm_out_nxt_s[c*DATA_W +: DATA_W] = rdata_s[c];
            end
        end
    end

    // Write pointer, fill level, active delays, load state and output regs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_r           <= '0;
            fill_r         <= '0;
            pend_idx_r     <= '0;
            load_pending_r <= 1'b0;
            out_valid_r    <= 1'b0;
            pcm_out_r      <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                act_r[c] <= '0;
            end
        end else begin
            pend_idx_r     <= pend_idx_nxt_s;
            load_pending_r <= load_pending_nxt_s;
            out_valid_r    <= bus.sample_valid;
            if (bus.sample_valid) begin
                wp_r      <= wp_r + DEL_W'(1);
                pcm_out_r <= pcm_out_nxt_s;
                if (fill_r != FILL_MAX) begin
                    fill_r <= fill_r + DEL_W'(1);
                end
                if (load_pending_r) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        act_r[c] <= tbl_r[pend_idx_r][c];
                    end
                end
            end
        end
    end

    // Preset table: cleared on reset, one entry written per cfg_wr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PRESETS; p++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    tbl_r[p][c] <= '0;
                end
            end
        end else if (bus.cfg_wr) begin
            tbl_r[bus.cfg_preset][bus.cfg_ch] <= bus.cfg_delay;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sample_delay_ram #(
            .DEPTH  (MAX_DELAY),
            .DATA_W (DATA_W),
            .ADDR_W (DEL_W)
        ) u_ram (
            .clk   (clk),
            .we    (bus.sample_valid),
            .waddr (wp_r),
            .wdata (bus.pcm_in[c*DATA_W +: DATA_W]),
            .raddr (raddr_s[c]),
            .rdata (rdata_s[c])
        );
    end

    assign bus.load_pending = load_pending_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.pcm_out      = pcm_out_r;

endmodule

// File: doc/steerable_delay_array.md
# steerable_delay_array

Parametrised per-channel sample delay for the mic-array beamformer front end. It takes NUM_CH PCM streams sharing one sample strobe and delays each one by a whole number of samples, 0 to MAX_DELAY-1. Delays come from a runtime-writable table of steering presets, and a preset switch takes effect on every channel at the same sample. The block sits between the PCM decimators and the channel summer.

## Interface
Parameters:
- NUM_CH, default 8: number of microphone channels.
- DATA_W, default 19: PCM sample width, two's complement.
- MAX_DELAY, default 32: delay-line depth in samples; must be a power of 2 and at least 2.
- NUM_PRESETS, default 16: number of steering presets in the table.
- Derived: DEL_W = clog2(MAX_DELAY); PS_W = clog2(NUM_PRESETS); CH_W = clog2(NUM_CH).

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset, asynchronous, active-high.
- sample_valid  in  1  one-cycle strobe; pcm_in holds a new sample set.
- pcm_in  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- cfg_wr  in  1  write one table entry.
- cfg_preset  in  PS_W  preset index of the entry being written.
- cfg_ch  in  CH_W  channel index of the entry being written.
- cfg_delay  in  DEL_W  delay in samples.
- preset_sel  in  PS_W  preset to apply.
- preset_load  in  1  request to apply preset_sel.
- load_pending  out  1  a load request is waiting for the next sample boundary.
- out_valid  out  1  one-cycle strobe; pcm_out holds a new sample set.
- pcm_out  out  NUM_CH*DATA_W  delayed samples, same channel packing as pcm_in.

## Operation
- All channels share one write pointer `wp` (DEL_W bits). On sample_valid each channel stores pcm_in[c] at `wp`, then `wp` increments and wraps from MAX_DELAY-1 to 0.
- Channel c reads the entry written d_c samples before the current one. d_c = 0 passes the current sample through, delayed only by pipeline latency.
- Fill counter `fill`:
  - Saturating, range 0 to MAX_DELAY-1.
  - Counts sample_valid events since reset.
  - If d_c > fill, channel c outputs 0. No stale or uninitialised RAM data ever reaches the output.
- Preset table:
  - NUM_PRESETS × NUM_CH entries of DEL_W bits; all entries 0 at reset.
  - cfg_wr writes table[cfg_preset][cfg_ch] = cfg_delay on that clock edge.
  - Write takes priority over nothing; a write never stalls.
- Active delay registers act[c] are 0 at reset.
- Preset apply:
  - preset_load latches preset_sel into `pend_idx` and sets load_pending.
  - A second load before the apply overwrites pend_idx; the last request wins.
  - On the next sample_valid, act[] is loaded from table[pend_idx] before that sample is read. All channels switch on the same sample, with no mixed-preset output.
  - load_pending clears on that same edge.
- preset_load and sample_valid asserted in the same cycle: the load waits for the following sample_valid.
- cfg_wr in the same cycle as an apply to the same entry: the old value is applied and the new value is stored in the table.
- Reset during operation clears wp, fill, act[], pend_idx, load_pending, the table, out_valid and pcm_out. RAM contents are not cleared; they are masked by `fill`.

## Timing
- Latency is 1 cycle: out_valid is asserted the cycle after sample_valid, and pcm_out is registered and held until the next out_valid.
- Reset values: out_valid = 0, pcm_out = 0, load_pending = 0.
- sample_valid must be at least 2 cycles apart. Back-to-back strobes are unsupported.
- The delay register update is bound to the sample edge, so a delay change shows on the first out_valid after the applying sample.
- Read address per channel is (wp − d_c) mod MAX_DELAY, computed with DEL_W-bit wrap arithmetic.

## Structure
- Package `mic_array_pkg`:
  - Default constants PCM_W = 19, NUM_MICS = 8, MAX_DELAY = 32.
  - A function packing/unpacking the flat channel bus.
- Sub-module `sample_delay_ram`: one per channel via generate.
  - Contents: MAX_DELAY × DATA_W storage, synchronous write, registered read at the given address.
  - Ports: clk, we, waddr, wdata, raddr, rdata.
- The top level holds wp, fill, the preset table, act[], the load logic and the output zero-masking.

## Test plan
- Reset, all delays 0, ramp pcm_in[c] = 100·c + n for 4 samples → each out_valid 1 cycle after its strobe; pcm_out equals the same sample; load_pending = 0.
- Preset 3 = {0,4,10,12,14,18,0,0}, load 3, then 40 samples of ramp n → ch1 = n−4 and ch5 = n−18 once filled; the first 18 outputs of ch5 are 0.
- Delay 31 on ch7, run 70 samples → ch7 = n−31 across wp wrap-around, with no glitch at wp = 0.
- Preset 1 active (all 5), load preset 2 (all 9) mid-stream → load_pending high until the next strobe; every channel jumps from n−5 to n−9 on the same out_valid.
- preset_load with sample_valid in the same cycle, plus cfg_wr to the applied entry in the apply cycle → the switch happens one sample later using the old entry value; a subsequent reload picks up the new value.
- Assert rst mid-stream with delay 10 active → pcm_out = 0 and out_valid = 0 immediately; after release with delays 0, the first output equals the first new input.
